// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divide unit for an in-order pipeline.
// Restoring shift-subtract on operand magnitudes, one quotient bit per cycle,
// with sign fix-up applied on the final step. Divide-by-zero and signed
// overflow skip the iteration and complete one cycle after capture.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      EX stage holds a divide-class instruction
//   func_3     100 DIV, 101 DIVU, 110 REM, 111 REMU (func_3[2]=0 ignored)
//   operand_a  dividend (rs1)
//   operand_b  divisor (rs2)
//   flush      pipeline flush, aborts any operation
//   stall      freeze IF/ID/EX while a divide is pending
//   busy       iteration in progress
//   done       one-cycle pulse, result valid
//   result     quotient or remainder, held until the next completion
module div_sequencer #(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func_3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            is_rem_q, is_rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            req;
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, ovf;

    logic [XLEN:0]   shifted, diff;
    logic            take;
    logic [XLEN-1:0] rem_nx, quo_nx;
    logic [XLEN-1:0] q_fin, r_fin;

    assign req       = start & func_3[2];
    assign is_signed = ~func_3[0];
    assign a_neg     = is_signed & operand_a[XLEN-1];
    assign b_neg     = is_signed & operand_b[XLEN-1];
    assign a_mag     = a_neg ? (-operand_a) : operand_a;
    assign b_mag     = b_neg ? (-operand_b) : operand_b;
    assign div_zero  = (operand_b == '0);
    assign ovf       = is_signed & (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                                 & (operand_b == '1);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The borrow bit of the
    // XLEN+1 wide difference decides the quotient bit.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign take    = ~diff[XLEN];
    assign rem_nx  = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nx  = {quo_q[XLEN-2:0], take};
    assign q_fin   = q_neg_q ? (-quo_nx) : quo_nx;
    assign r_fin   = r_neg_q ? (-rem_nx) : rem_nx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        stall    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req && !flush) begin
                    stall    = 1'b1;
                    is_rem_d = func_3[1];
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    rem_d    = '0;
                    quo_d    = a_mag;
                    dvs_d    = b_mag;
                    cnt_d    = '0;
                    if (div_zero) begin
                        result_d = func_3[1] ? operand_a : '1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = func_3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                stall = 1'b1;
                busy  = 1'b1;
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    result_d = is_rem_q ? r_fin : q_fin;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // The instruction is still in EX this cycle; start is ignored.
                done    = ~flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides capture and completion alike.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL declare parameter XLEN, default 32, operand/result width.
REQ-002 SHALL declare parameter ITER, default XLEN, division iterations (one quotient bit per cycle).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  EX stage holds a RV32M divide-class instruction.
REQ-006 func_3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; func_3[2]=0 SHALL be ignored (no request).
REQ-007 operand_a  input  XLEN  dividend (rs1).
REQ-008 operand_b  input  XLEN  divisor (rs2).
REQ-009 flush  input  1  pipeline flush; aborts any operation.
REQ-010 stall  output  1  freeze IF/ID/EX while divide pending.
REQ-011 busy  output  1  high in RUN state.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 result  output  XLEN  quotient or remainder per func_3.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 req = start & func_3[2]; IDLE & req & ~flush SHALL capture operands, func_3 and sign flags at the edge.
REQ-016 Capture with operand_b==0 or (signed op, operand_a==0x80000000, operand_b==0xFFFFFFFF) SHALL go IDLE->DONE directly (latency 1).
REQ-017 Otherwise IDLE->RUN; 5-bit iteration counter cleared on capture.
REQ-018 RUN SHALL perform one restoring shift-subtract step per cycle on magnitudes (|a|,|b| for signed ops); after ITER steps RUN->DONE.
REQ-019 Normal latency: req at cycle T -> done high in cycle T+ITER+1 (T+33 default).
REQ-020 DONE SHALL last exactly one cycle, assert done, then go IDLE; start is ignored in DONE (same instruction still present).
REQ-021 stall = (IDLE & req & ~flush) | RUN; stall SHALL be low in DONE so the pipeline advances with result.
REQ-022 DIV quotient sign = sign(a) XOR sign(b); REM remainder sign = sign(a); unsigned ops no correction.
REQ-023 Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = operand_a.
REQ-024 Signed overflow (REQ-016 case): DIV result 0x80000000; REM result 0.
REQ-025 result SHALL hold its last value from DONE until the next DONE.
REQ-026 flush SHALL have priority over start and completion: from any state, next state IDLE, done not asserted, result unchanged.
REQ-027 Back-to-back divides: new req in the IDLE cycle after DONE SHALL be accepted with no extra bubble.

Reset
REQ-028 rst high SHALL immediately force IDLE, counter 0, busy 0, done 0, stall 0 (when start low), result 0, internal registers 0.
REQ-029 rst asserted mid-RUN SHALL abandon the operation with no done pulse after release.
REQ-030 First req SHALL be accepted on the first rising edge with rst low.

Verification
REQ-031 DIVU a=100, b=7 at T -> stall high T..T+32, busy T+1..T+32, done and result=14 at T+33.
REQ-032 REM a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFF (-1); DIV same operands -> 0xFFFFFFFD (-3).
REQ-033 DIV a=5, b=0 -> done at T+1, result 0xFFFFFFFF; REMU a=5, b=0 -> result 5.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> result 0x80000000 at T+1; REM same -> 0.
REQ-035 DIVU started at T, flush at T+10 -> busy 0 at T+11, no done, result unchanged; DIVU 9/3 started at T+12 -> result 3 at T+45.
REQ-036 rst pulsed at T+5 of a DIV -> all outputs 0 immediately, no done pulse within 40 cycles with start low.
